alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 8-bit ALU for the virtual CPU.
- Accepts one instruction per valid/ready handshake and reads operands from an internal register file.
- Drives the external ALU's opcode/A/B inputs, captures Result and the Zero/Carry/Negative flags, and writes the result back.
- Sits between instruction fetch and the ALU. The ALU stays purely combinational; this block owns all state.

---
 rtl/alu_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle controller that sequences an external, purely combinational
// 8-bit ALU. It accepts one instruction per valid/ready handshake, reads the
// operands from an internal register file, drives the ALU inputs, captures
// the result and flags, and writes the result back to the register file.
// Each instruction takes four cycles: IDLE (accept), READ, EXEC and WB.
//
// Instruction layout (INSTR_W = 12 + 2*REG_AW):
//   [INSTR_W-1]              imm_sel : 1 = B operand is the immediate
//   [INSTR_W-2:INSTR_W-4]    aluop   : 3-bit ALU operation
//   next REG_AW bits         rd      : destination register, and B operand
//                                      when imm_sel = 0
//   next REG_AW bits         rs      : A operand register
//   [7:0]                    imm     : 8-bit immediate
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   instr_valid    in   instruction offered
//   instr_ready    out  sequencer can accept (high only in IDLE)
//   instr          in   instruction word
//   alu_opcode     out  ALU opcode, {5'b0, aluop}
//   alu_a          out  ALU A operand
//   alu_b          out  ALU B operand
//   alu_result     in   ALU result
//   alu_zero       in   ALU zero flag
//   alu_carry      in   ALU carry/borrow flag
//   alu_negative   in   ALU negative flag
//   flags          out  registered {negative, carry, zero}
//   done           out  one-cycle pulse during writeback
//   dbg_sel        in   debug register select
//   dbg_data       out  combinational read of reg[dbg_sel]
//
// Optional feature (macro ALU_SEQ_PERF_EN):
//   retired_cnt    out  16-bit count of writebacks, wraps
//   busy_cnt       out  16-bit count of non-IDLE cycles, wraps
//
// NUM_REGS must equal 2**REG_AW; INSTR_W is derived and must not be
// overridden.
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2,
  parameter int INSTR_W  = 12 + 2 * REG_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [7:0]         alu_opcode,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_negative,
  output logic [2:0]         flags,
  output logic               done,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [7:0]         dbg_data
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]        retired_cnt,
  output logic [15:0]        busy_cnt
`endif
);

  // -------------------------------------------------------------------------
  // State machine encoding
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // Latched instruction and its decoded fields
  // -------------------------------------------------------------------------
  logic [INSTR_W-1:0] instr_reg;

  logic              imm_sel;
  logic [2:0]        aluop;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [7:0]        imm;

  assign imm_sel = instr_reg[INSTR_W-1];
  assign aluop   = instr_reg[INSTR_W-2 -: 3];
  assign rd      = instr_reg[INSTR_W-5 -: REG_AW];
  assign rs      = instr_reg[INSTR_W-5-REG_AW -: REG_AW];
  assign imm     = instr_reg[7:0];

  // -------------------------------------------------------------------------
  // Result/flag holding registers, loaded at the edge that closes EXEC so
  // that WB writes values the ALU produced from stable inputs.
  // -------------------------------------------------------------------------
  logic [7:0] result_hold;
  logic [2:0] flags_hold;

  // -------------------------------------------------------------------------
  // Register file. Each register is its own flop group with a decoded write
  // enable; the array view below is only used for the read ports.
  // -------------------------------------------------------------------------
  logic [7:0] regs [NUM_REGS];
  logic       wb_en;

  assign wb_en = (state == WB);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regfile
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= 8'h00;
        end else if (wb_en && (rd == REG_AW'(gi))) begin
          q_reg <= result_hold;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  // Debug read is combinational; a WB write shows up the following cycle.
  assign dbg_data = regs[dbg_sel];

  // -------------------------------------------------------------------------
  // Main FSM with registered outputs.
  //
  // instr_ready and done are registered and therefore set one state ahead:
  // ready is raised on the WB->IDLE transition (and by reset), done is
  // raised on the EXEC->WB transition and dropped on leaving WB.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_reg   <= '0;
      instr_ready <= 1'b1;
      alu_opcode  <= 8'h00;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      result_hold <= 8'h00;
      flags_hold  <= 3'b000;
      flags       <= 3'b000;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (instr_valid && instr_ready) begin
            instr_reg   <= instr;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end

        READ: begin
          // rd == rs is legal: both reads see the value before this
          // instruction's writeback.
          alu_a      <= regs[rs];
          alu_b      <= imm_sel ? imm : regs[rd];
          alu_opcode <= {5'b00000, aluop};
          state      <= EXEC;
        end

        EXEC: begin
          result_hold <= alu_result;
          flags_hold  <= {alu_negative, alu_carry, alu_zero};
          done        <= 1'b1;
          state       <= WB;
        end

        WB: begin
          // The register file write happens in g_regfile under wb_en.
          flags       <= flags_hold;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          done        <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters: both wrap naturally at 16 bits.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 16'h0000;
      busy_cnt    <= 16'h0000;
    end else begin
      if (state == WB) begin
        retired_cnt <= retired_cnt + 16'h0001;
      end
      if (state != IDLE) begin
        busy_cnt <= busy_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed testbench for alu_sequencer. A small combinational ALU model
// stands in for the external ALU with this opcode map:
//   0 ADD   1 SUB (carry = borrow)   2 AND   3 OR   4 XOR
//   5 SHL   6 SHR (B ignored)        7 MOVB (result = B)
// Carry is 0 for everything except ADD/SUB. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_negative;
  logic [2:0]  flags;
  logic        done;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] retired_cnt;
  logic [15:0] busy_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_negative (alu_negative),
    .flags        (flags),
    .done         (done),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
`ifdef ALU_SEQ_PERF_EN
    ,
    .retired_cnt  (retired_cnt),
    .busy_cnt     (busy_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  logic [8:0] alu_tmp;
  logic [7:0] alu_res;
  logic       alu_cy;
  always_comb begin
    alu_tmp = 9'd0;
    alu_res = 8'h00;
    alu_cy  = 1'b0;
    case (alu_opcode[2:0])
      3'd0: begin alu_tmp = {1'b0, alu_a} + {1'b0, alu_b}; alu_res = alu_tmp[7:0]; alu_cy = alu_tmp[8]; end
      3'd1: begin alu_tmp = {1'b0, alu_a} - {1'b0, alu_b}; alu_res = alu_tmp[7:0]; alu_cy = alu_tmp[8]; end
      3'd2: alu_res = alu_a & alu_b;
      3'd3: alu_res = alu_a | alu_b;
      3'd4: alu_res = alu_a ^ alu_b;
      3'd5: alu_res = {alu_a[6:0], 1'b0};
      3'd6: alu_res = {1'b0, alu_a[7:1]};
      default: alu_res = alu_b;
    endcase
    alu_result   = alu_res;
    alu_zero     = (alu_res == 8'h00);
    alu_negative = alu_res[7];
    alu_carry    = alu_cy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [15:0] mk(input logic sel, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] rs,
                                      input logic [7:0] imm);
    return {sel, op, rd, rs, imm};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    dbg_sel = idx;
    #1;
    check(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // Issue one instruction and wait for done; returns one idle cycle after WB.
  task automatic run_instr(input logic [15:0] ins, input string tag);
    int n;
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    for (n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({tag, "_latency"}, n, 3);
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] rd, input logic [7:0] v);
    run_instr(mk(1'b1, 3'd7, rd, 2'd0, v), "load");
  endtask

  logic [15:0] q [3];
  int idx, dones, readies;
  int done_cyc [3];
  bit saw_done;

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_sel = 2'd0;

    // ---- reset state ----
    do_reset();
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_flags", flags, 3'b000);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_opcode", alu_opcode, 0);
    for (int i = 0; i < 4; i++) read_reg(2'(i), 8'h00, "rst_reg");

    // ---- imm ADD rd0 rs0 imm 05 ----
    run_instr(mk(1'b1, 3'd0, 2'd0, 2'd0, 8'h05), "add_imm");
    read_reg(2'd0, 8'h05, "add_imm_reg0");
    check("add_imm_flags", flags, 3'b000);
    check("add_imm_opcode", alu_opcode, 8'h00);
    check("add_imm_b", alu_b, 8'h05);

    // ---- FF + 1 -> 00, carry and zero ----
    load(2'd0, 8'hFF);
    run_instr(mk(1'b1, 3'd0, 2'd1, 2'd0, 8'h01), "add_wrap");
    read_reg(2'd1, 8'h00, "add_wrap_reg1");
    check("add_wrap_flags", flags, 3'b011);

    // ---- reg SUB rd1 rs0: 3 - 5 = FE, borrow, negative ----
    load(2'd0, 8'h03);
    load(2'd1, 8'h05);
    run_instr(mk(1'b0, 3'd1, 2'd1, 2'd0, 8'h00), "sub_reg");
    read_reg(2'd1, 8'hFE, "sub_reg_reg1");
    check("sub_reg_flags", flags, 3'b110);
    check("sub_reg_a", alu_a, 8'h03);
    check("sub_reg_b", alu_b, 8'h05);

    // ---- rd == rs uses the pre-write value: FE + FE = FC, carry ----
    run_instr(mk(1'b0, 3'd0, 2'd1, 2'd1, 8'h00), "add_self");
    read_reg(2'd1, 8'hFC, "add_self_reg1");
    repeat (3) @(negedge clk);
    check("flags_held", flags, 3'b110);

    // ---- SHL, B is driven with imm but ignored: FC << 1 = F8 ----
    run_instr(mk(1'b1, 3'd5, 2'd0, 2'd1, 8'hAA), "shl");
    read_reg(2'd0, 8'hF8, "shl_reg0");
    check("shl_flags", flags, 3'b100);
    check("shl_b", alu_b, 8'hAA);
    check("shl_opcode", alu_opcode, 8'h05);

    // ---- valid held high with 3 queued instructions ----
    q[0] = mk(1'b1, 3'd7, 2'd2, 2'd0, 8'h10);   // reg2 = 10
    q[1] = mk(1'b0, 3'd0, 2'd3, 2'd2, 8'h00);   // reg3 = reg2 + reg3 = 10
    q[2] = mk(1'b1, 3'd1, 2'd2, 2'd3, 8'h01);   // reg2 = reg3 - 1 = 0F
    idx = 0; dones = 0; readies = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int c = 0; c < 40 && dones < 3; c++) begin
      if (idx < 3) instr = q[idx];
      if (done) begin
        if (dones < 3) done_cyc[dones] = c;
        dones++;
      end
      if (instr_ready) begin
        readies++;
        check("q_ready_cycle", c, idx * 4);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx >= 3) instr_valid = 1'b0;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("q_done_count", dones, 3);
    check("q_ready_count", readies, 3);
    check("q_done0", done_cyc[0], 3);
    check("q_done1", done_cyc[1], 7);
    check("q_done2", done_cyc[2], 11);
    @(negedge clk);
    read_reg(2'd2, 8'h0F, "q_reg2");
    read_reg(2'd3, 8'h10, "q_reg3");
    check("q_flags", flags, 3'b000);

    // ---- reset during EXEC of ADD rd2 ----
    @(negedge clk);
    instr = mk(1'b1, 3'd0, 2'd2, 2'd2, 8'h33);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    saw_done = 1'b0;
    @(negedge clk);                 // READ
    if (done) saw_done = 1'b1;
    @(negedge clk);                 // EXEC
    if (done) saw_done = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_mid_ready", instr_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", saw_done, 0);
    read_reg(2'd2, 8'h00, "rst_mid_reg2");
    check("rst_mid_flags", flags, 3'b000);
    check("rst_mid_ready_idle", instr_ready, 1);

`ifdef ALU_SEQ_PERF_EN
    run_instr(mk(1'b1, 3'd0, 2'd0, 2'd0, 8'h01), "perf0");
    run_instr(mk(1'b1, 3'd0, 2'd0, 2'd0, 8'h01), "perf1");
    check("perf_retired", retired_cnt, 2);
    check("perf_busy", busy_cnt, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
